// File: rtl/relu_pool.sv
// ============================================================================
// Module   : relu_pool
// Brief    : ReLU + KxK max-pool with shift/saturate, one window element/clk.
// Revision : 1.0
// ============================================================================
`default_nettype none

module relu_pool #(
    parameter int IN_WIDTH    = 3,
    parameter int IN_HEIGHT   = 3,
    parameter int BITWIDTH    = 16,
    parameter int EXPAND      = 1,
    parameter int POOL_SIZE   = 2,
    parameter int POOL_STRIDE = 1,
    parameter int SHIFT       = 0,
    parameter int OUT_WIDTH   = (IN_WIDTH - POOL_SIZE) / POOL_STRIDE + 1,
    parameter int OUT_HEIGHT  = (IN_HEIGHT - POOL_SIZE) / POOL_STRIDE + 1
) (
    input  logic                                             clk_en,
    input  logic                                             rst,
    input  logic                                             pool_en,
    input  logic [2*EXPAND*IN_WIDTH*IN_HEIGHT*BITWIDTH-1:0]  conv_result,
    output logic [OUT_WIDTH*OUT_HEIGHT*BITWIDTH-1:0]         result,
    output logic                                             busy,
    output logic                                             pool_fin
);

    localparam int c_ew    = 2 * EXPAND * BITWIDTH;
    localparam int c_n_in  = IN_WIDTH * IN_HEIGHT;
    localparam int c_n_out = OUT_WIDTH * OUT_HEIGHT;
    localparam int c_iw    = (c_n_in > 1)     ? $clog2(c_n_in)     : 1;
    localparam int c_ow    = (c_n_out > 1)    ? $clog2(c_n_out)    : 1;
    localparam int c_kw    = (POOL_SIZE > 1)  ? $clog2(POOL_SIZE)  : 1;
    localparam int c_xw    = (OUT_WIDTH > 1)  ? $clog2(OUT_WIDTH)  : 1;
    localparam int c_yw    = (OUT_HEIGHT > 1) ? $clog2(OUT_HEIGHT) : 1;

    localparam logic [c_kw-1:0]     c_k_last = c_kw'(POOL_SIZE - 1);
    localparam logic [c_xw-1:0]     c_x_last = c_xw'(OUT_WIDTH - 1);
    localparam logic [c_yw-1:0]     c_y_last = c_yw'(OUT_HEIGHT - 1);
    localparam logic [BITWIDTH-1:0] c_max    = {BITWIDTH{1'b1}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                     r_state;
    logic signed [c_ew-1:0]     r_buf [c_n_in];
    logic signed [c_ew-1:0]     r_acc;
    logic [BITWIDTH-1:0]        r_res [c_n_out];
    logic [c_yw-1:0]            r_oy;
    logic [c_xw-1:0]            r_ox;
    logic [c_kw-1:0]            r_ky;
    logic [c_kw-1:0]            r_kx;
    logic                       r_busy;
    logic                       r_fin;

    logic signed [c_ew-1:0]     w_in [c_n_in];
    logic [c_iw-1:0]            w_idx;
    logic [c_ow-1:0]            w_slot;
    logic signed [c_ew-1:0]     w_x;
    logic signed [c_ew-1:0]     w_relu;
    logic signed [c_ew-1:0]     w_max;
    logic signed [c_ew-1:0]     w_shifted;
    logic [BITWIDTH-1:0]        w_sat;
    logic                       w_win_first;
    logic                       w_win_last;

    generate
        for (genvar gi = 0; gi < c_n_in; gi++) begin : g_unpack
            assign w_in[gi] = conv_result[gi*c_ew +: c_ew];
        end
        for (genvar go = 0; go < c_n_out; go++) begin : g_pack
            assign result[go*BITWIDTH +: BITWIDTH] = r_res[go];
        end
    endgenerate

    assign busy     = r_busy;
    assign pool_fin = r_fin;

    // Single shared comparator: current element against the running window max.
    always_comb begin
        w_idx       = c_iw'((int'(r_oy) * POOL_STRIDE + int'(r_ky)) * IN_WIDTH
                            + int'(r_ox) * POOL_STRIDE + int'(r_kx));
        w_slot      = c_ow'(int'(r_oy) * OUT_WIDTH + int'(r_ox));
        w_x         = r_buf[w_idx];
        w_relu      = w_x[c_ew-1] ? '0 : w_x;
        w_win_first = (r_ky == '0) && (r_kx == '0);
        w_win_last  = (r_ky == c_k_last) && (r_kx == c_k_last);
        w_max       = (w_win_first || (w_relu > r_acc)) ? w_relu : r_acc;
        w_shifted   = w_max >>> SHIFT;
        w_sat       = (|w_shifted[c_ew-1:BITWIDTH]) ? c_max : w_shifted[BITWIDTH-1:0];
    end

    always_ff @(posedge clk_en or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_acc   <= '0;
            r_oy    <= '0;
            r_ox    <= '0;
            r_ky    <= '0;
            r_kx    <= '0;
            r_busy  <= 1'b0;
            r_fin   <= 1'b0;
            for (int i = 0; i < c_n_in; i++) begin
                r_buf[i] <= '0;
            end
            for (int j = 0; j < c_n_out; j++) begin
                r_res[j] <= '0;
            end
        end else begin
            case (r_state)
                IDLE: begin
                    r_fin <= 1'b0;
                    if (pool_en) begin
                        for (int i = 0; i < c_n_in; i++) begin
                            r_buf[i] <= w_in[i];
                        end
                        r_acc   <= '0;
                        r_oy    <= '0;
                        r_ox    <= '0;
                        r_ky    <= '0;
                        r_kx    <= '0;
                        r_busy  <= 1'b1;
                        r_state <= SCAN;
                    end else begin
                        r_busy <= 1'b0;
                    end
                end

                SCAN: begin
                    r_acc <= w_max;
                    if (w_win_last) begin
                        r_res[w_slot] <= w_sat;
                    end
                    // Nested row-major walk: kx fastest, then ky, ox, oy.
                    if (r_kx != c_k_last) begin
                        r_kx <= r_kx + 1'b1;
                    end else begin
                        r_kx <= '0;
                        if (r_ky != c_k_last) begin
                            r_ky <= r_ky + 1'b1;
                        end else begin
                            r_ky <= '0;
                            if (r_ox != c_x_last) begin
                                r_ox <= r_ox + 1'b1;
                            end else begin
                                r_ox <= '0;
                                if (r_oy != c_y_last) begin
                                    r_oy <= r_oy + 1'b1;
                                end else begin
                                    r_oy    <= '0;
                                    r_fin   <= 1'b1;
                                    r_state <= DONE;
                                end
                            end
                        end
                    end
                end

                DONE: begin
                    r_fin   <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end

                default: begin
                    r_fin   <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_relu_pool.sv
// ============================================================================
// Module   : tb_relu_pool
// Brief    : Scoreboard bench for relu_pool across three parameter sets.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_relu_pool;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [511:0] conv_bus  [3];
    logic         pool_en_v [3];
    logic [63:0]  res_bus   [3];
    logic         busy_v    [3];
    logic         fin_v     [3];

    always #5 clk = ~clk;

    // Instance 0: defaults. Instance 1: shift 4. Instance 2: 4x4 input, stride 2.
    relu_pool #(.IN_WIDTH(3), .IN_HEIGHT(3), .BITWIDTH(16), .EXPAND(1),
                .POOL_SIZE(2), .POOL_STRIDE(1), .SHIFT(0)) dut_base (
        .clk_en(clk), .rst(rst), .pool_en(pool_en_v[0]),
        .conv_result(conv_bus[0][287:0]), .result(res_bus[0]),
        .busy(busy_v[0]), .pool_fin(fin_v[0]));

    relu_pool #(.IN_WIDTH(3), .IN_HEIGHT(3), .BITWIDTH(16), .EXPAND(1),
                .POOL_SIZE(2), .POOL_STRIDE(1), .SHIFT(4)) dut_shift (
        .clk_en(clk), .rst(rst), .pool_en(pool_en_v[1]),
        .conv_result(conv_bus[1][287:0]), .result(res_bus[1]),
        .busy(busy_v[1]), .pool_fin(fin_v[1]));

    relu_pool #(.IN_WIDTH(4), .IN_HEIGHT(4), .BITWIDTH(16), .EXPAND(1),
                .POOL_SIZE(2), .POOL_STRIDE(2), .SHIFT(0)) dut_stride (
        .clk_en(clk), .rst(rst), .pool_en(pool_en_v[2]),
        .conv_result(conv_bus[2]), .result(res_bus[2]),
        .busy(busy_v[2]), .pool_fin(fin_v[2]));

    typedef struct {
        int          inst;
        int          start;
        int          fin;
        logic [63:0] res;
    } exp_t;

    exp_t        sb[$];
    int          cyc   = 0;
    int          n_cmp = 0;
    int          n_err = 0;
    bit          done  = 1'b0;
    logic [63:0] exp_res  [3];
    int          last_fin [3];

    logic [511:0] nxt_conv  [3];
    logic         nxt_en    [3];
    logic         nxt_lit_v [3];
    logic [63:0]  nxt_lit   [3];
    logic         nxt_rst;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference: every output window computed directly from the whole input.
    function automatic logic [63:0] model(input int inst, input logic [511:0] conv);
        int          w  = (inst == 2) ? 4 : 3;
        int          s  = (inst == 2) ? 2 : 1;
        int          sh = (inst == 1) ? 4 : 0;
        logic [63:0] r  = '0;
        for (int oy = 0; oy < 2; oy++) begin
            for (int ox = 0; ox < 2; ox++) begin
                longint mx = 0;
                for (int ky = 0; ky < 2; ky++) begin
                    for (int kx = 0; kx < 2; kx++) begin
                        int idx = (oy * s + ky) * w + ox * s + kx;
                        logic signed [31:0] e = conv[idx*32 +: 32];
                        if (longint'(e) > mx) mx = longint'(e);
                    end
                end
                mx = mx >>> sh;
                if (mx > 65535) mx = 65535;
                r[(oy*2+ox)*16 +: 16] = mx[15:0];
            end
        end
        return r;
    endfunction

    function automatic logic [31:0] rnd_el();
        case ($urandom_range(0, 3))
            0:       return 32'($urandom_range(0, 100));
            1:       return -32'($urandom_range(1, 1000));
            2:       return 32'($urandom);
            default: return 32'($urandom_range(0, 32'h000F_FFFF));
        endcase
    endfunction

    task automatic rnd_conv(input int i);
        for (int k = 0; k < 16; k++) nxt_conv[i][k*32 +: 32] = rnd_el();
    endtask

    task automatic fill_conv(input int i, input logic [31:0] v);
        for (int k = 0; k < 16; k++) nxt_conv[i][k*32 +: 32] = v;
    endtask

    task automatic set_lit(input int i, input logic [63:0] v);
        nxt_lit_v[i] = 1'b1;
        nxt_lit[i]   = v;
    endtask

    // Apply the staged stimulus at the falling edge; predict pass starts.
    task automatic step();
        @(negedge clk);
        rst = nxt_rst;
        if (nxt_rst) begin
            sb.delete();
            for (int i = 0; i < 3; i++) last_fin[i] = -100;
        end
        for (int i = 0; i < 3; i++) begin
            conv_bus[i]  = nxt_conv[i];
            pool_en_v[i] = nxt_en[i];
            if (nxt_en[i] && !nxt_rst && (cyc + 1 >= last_fin[i] + 2)) begin
                exp_t e;
                e.inst  = i;
                e.start = cyc + 1;
                e.fin   = cyc + 1 + 16;
                e.res   = nxt_lit_v[i] ? nxt_lit[i] : model(i, nxt_conv[i]);
                sb.push_back(e);
                last_fin[i] = e.fin;
            end
            nxt_lit_v[i] = 1'b0;
        end
    endtask

    task automatic all_en(input logic v);
        for (int i = 0; i < 3; i++) nxt_en[i] = v;
    endtask

    task automatic chk(input string name, input int i, input logic [63:0] got,
                       input logic [63:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s[%0d] cyc=%0d: got %h, want %h", name, i, cyc, got, want);
        end
    endtask

    task automatic check_inst(input int i);
        int   h = -1;
        logic eb;
        logic ef;
        if (rst) begin
            chk("reset_result", i, res_bus[i], 64'h0);
            chk("reset_busy_fin", i, {62'h0, busy_v[i], fin_v[i]}, 64'h0);
            exp_res[i] = '0;
            return;
        end
        for (int j = 0; j < sb.size(); j++) begin
            if (sb[j].inst == i) begin
                h = j;
                break;
            end
        end
        eb = (h >= 0) && (cyc >= sb[h].start);
        ef = (h >= 0) && (cyc == sb[h].fin);
        chk("busy", i, {63'h0, busy_v[i]}, {63'h0, eb});
        chk("pool_fin", i, {63'h0, fin_v[i]}, {63'h0, ef});
        if (ef) begin
            chk("result", i, res_bus[i], sb[h].res);
            exp_res[i] = sb[h].res;
            sb.delete(h);
        end else if (h < 0 || cyc <= sb[h].start) begin
            chk("result_hold", i, res_bus[i], exp_res[i]);
        end
    endtask

    initial begin : monitor
        forever begin
            @(posedge clk);
            #1;
            for (int i = 0; i < 3; i++) check_inst(i);
            if (done) begin
                n_cmp++;
                if (sb.size() != 0) begin
                    n_err++;
                    $display("FAIL pending_passes: got %0d outstanding, want 0", sb.size());
                end
                $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
                $finish;
            end
        end
    end

    initial begin : driver
        for (int i = 0; i < 3; i++) begin
            conv_bus[i]  = '0;
            pool_en_v[i] = 1'b0;
            nxt_conv[i]  = '0;
            nxt_en[i]    = 1'b0;
            nxt_lit_v[i] = 1'b0;
            nxt_lit[i]   = '0;
            exp_res[i]   = '0;
            last_fin[i]  = -100;
        end
        nxt_rst = 1'b1;
        repeat (3) step();
        nxt_rst = 1'b0;
        repeat (2) step();

        // Nominal grid, single saturating element with shift 4, stride ramp.
        nxt_conv[0] = '0;
        nxt_conv[0][287:0] = {32'd4, 32'd12, 32'd13, 32'd9, 32'd2, 32'd10,
                              32'd7, 32'd9, 32'd4};
        set_lit(0, 64'h000C_000D_0009_000A);
        nxt_conv[1] = '0;
        nxt_conv[1][31:0] = 32'h0001_2345;
        set_lit(1, 64'h0000_0000_0000_1234);
        for (int k = 0; k < 16; k++) nxt_conv[2][k*32 +: 32] = 32'(k);
        set_lit(2, 64'h000F_000D_0007_0005);
        all_en(1'b1);
        step();
        all_en(1'b0);
        for (int i = 0; i < 3; i++) rnd_conv(i);
        repeat (4) step();
        // Request while busy, with different data: must be ignored.
        all_en(1'b1);
        step();
        all_en(1'b0);
        repeat (16) step();

        // All-negative input on every instance.
        for (int i = 0; i < 3; i++) begin
            fill_conv(i, 32'hFFFF_FFF0);
            set_lit(i, 64'h0);
        end
        all_en(1'b1);
        step();
        all_en(1'b0);
        repeat (18) step();

        // Saturation without shift.
        nxt_conv[0] = '0;
        nxt_conv[0][31:0] = 32'h0001_2345;
        set_lit(0, 64'h0000_0000_0000_FFFF);
        nxt_en[0] = 1'b1;
        step();
        nxt_en[0] = 1'b0;
        repeat (18) step();

        // Reset in the middle of a pass, then a fresh nominal pass.
        for (int i = 0; i < 3; i++) rnd_conv(i);
        all_en(1'b1);
        step();
        all_en(1'b0);
        repeat (7) step();
        nxt_rst = 1'b1;
        repeat (2) step();
        nxt_rst = 1'b0;
        nxt_conv[0] = '0;
        nxt_conv[0][287:0] = {32'd4, 32'd12, 32'd13, 32'd9, 32'd2, 32'd10,
                              32'd7, 32'd9, 32'd4};
        set_lit(0, 64'h000C_000D_0009_000A);
        nxt_en[0] = 1'b1;
        step();
        nxt_en[0] = 1'b0;
        repeat (18) step();

        // pool_en held high: back-to-back passes restart from first IDLE cycle.
        all_en(1'b1);
        repeat (60) begin
            for (int i = 0; i < 3; i++) rnd_conv(i);
            step();
        end
        all_en(1'b0);
        repeat (20) step();

        // Randomized traffic with occasional resets.
        repeat (1500) begin
            for (int i = 0; i < 3; i++) begin
                if ($urandom_range(0, 1) == 0) rnd_conv(i);
                nxt_en[i] = ($urandom_range(0, 5) == 0);
            end
            nxt_rst = ($urandom_range(0, 299) == 0);
            step();
        end
        nxt_rst = 1'b0;
        all_en(1'b0);
        repeat (20) step();
        done = 1'b1;
    end

endmodule

`default_nettype wire

// File: doc/relu_pool.md
Name: relu_pool

Overview:
- Downstream stage of conv_top. Consumes the flattened convolution result vector when conv_fin is seen.
- Applies ReLU to the result, then max-pooling over a K×K window with stride S.
- Rescales each pooled value by a right shift and saturates it to bitwidth.
- Presents a flattened pooled vector and a one-cycle pool_fin strobe for the next layer (FC or the next conv).
- Window elements are scanned serially, one per clock, to keep comparator count at one.

Parameters:
- in_width, 3: conv result columns (matches conv_top result_width).
- in_height, 3: conv result rows (matches conv_top result_height).
- bitwidth, 16: output element width. Input element width is 2*expand*bitwidth.
- expand, 1: input width multiplier, as in conv_top.
- pool_size, 2: K, square window edge.
- pool_stride, 1: S.
- shift, 0: arithmetic right shift applied to the pooled max before saturation.
- out_width, (in_width-pool_size)/pool_stride+1: derived.
- out_height, (in_height-pool_size)/pool_stride+1: derived.

Ports:
- clk_en, in, 1: clock, rising edge.
- rst, in, 1: reset, asynchronous, active-high.
- pool_en, in, 1: start request; driven from conv_top conv_fin.
- conv_result, in, 2*expand*in_width*in_height*bitwidth: signed conv output, flattened.
- result, out, out_width*out_height*bitwidth: unsigned pooled output, flattened.
- busy, out, 1: high while a pooling pass is in progress.
- pool_fin, out, 1: one-cycle completion strobe.

Behaviour:
- Reset: clock is clk_en; reset is asynchronous, active-high on rst. While rst is high:
  - result=0, busy=0, pool_fin=0.
  - FSM goes to IDLE; all counters and the accumulator clear.
- Packing:
  - Element (r,c) occupies bits [(r*W+c)*EW +: EW], where W is the row width and EW the element width. r=0,c=0 is at the LSB.
  - This applies to both conv_result and result.
  - Input elements are two's complement.
- FSM states: IDLE, SCAN, DONE.
  - IDLE: if pool_en=1 at a rising edge (cycle T), latch conv_result into an internal buffer, clear the window counters, go to SCAN. busy=1 from T+1.
  - SCAN: one window element per cycle, in row-major order within the window. Windows are visited row-major over the output grid.
    - First element of each window: acc = relu(x).
    - Remaining elements: acc = max(acc, relu(x)).
    - On the last element of a window, write sat(max(acc,relu(x)) >>> shift) into result slot (or,oc). This write is the same edge as the last scan; it is not a separate cycle.
    - After the last window, go to DONE.
    - SCAN length is out_width*out_height*K*K cycles, T+1 through T+N*K*K.
  - DONE: exactly one cycle at T+1+N*K*K, with pool_fin=1 and busy=1. The next state is IDLE; busy=0 and pool_fin=0 from the following cycle.
- Arithmetic:
  - relu(x) = 0 if x<0, else x.
  - sat(v) = 2^bitwidth-1 if v ≥ 2^bitwidth, else v[bitwidth-1:0].
- Result holding:
  - Unwritten slots keep their prior value during a pass.
  - result holds its final value until the next pass overwrites slots, or until reset.
- pool_en handling:
  - pool_en is level-sampled, and only in IDLE.
  - pool_en high in SCAN or DONE is ignored; no queuing.
  - pool_en still high in the first IDLE cycle after DONE starts a new pass.
- conv_result may change after T without effect, because the buffer is latched at T.
- Reset mid-SCAN aborts immediately: result clears and no pool_fin is issued.

Test Plan:
- Nominal: conv_result rows {4,9,7},{10,2,9},{13,12,4}, defaults, pool_en pulse at T. Required: result {10,9},{13,12} (LSB-first 0x000C_000D_0009_000A), pool_fin high only at T+17, busy high T+1..T+17.
- ReLU: all inputs negative (e.g. 0xFFFF_FFF0). Required: result all 0, pool_fin at T+17.
- Saturation and shift:
  - One window max 0x0001_2345, shift=0. Required: slot 0xFFFF.
  - Same input with shift=4. Required: slot 0x1234.
- Busy ignore: second pool_en at T+5 with different data. Required: exactly one pool_fin at T+17 with first-pass results; new pass only if pool_en is reasserted after DONE.
- Reset mid-op: rst high at T+8 for 2 cycles. Required: result=0, busy=0, no pool_fin. A fresh pool_en then completes normally 17 cycles later.
- Stride: in 4×4 ramp 0..15, K=2, S=2. Required: result {5,7},{13,15}, pool_fin at T+1+4*4=T+17.
